// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage types and constants
package fetch_pkg;

    typedef enum logic [1:0] {
        S_VEC_HI = 2'd0,
        S_VEC_LO = 2'd1,
        S_OP     = 2'd2,
        S_IMM    = 2'd3
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h07F8;
    localparam int          IMM_BIT   = 2;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - PC register: redirect > vector load > stall-hold > increment
module fetch_pc_reg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (load) begin
            pc <= load_pc;
        end else if (!stall) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch FSM with two-word assembly; optional FETCH_RESET_VECTOR_EN
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic              inst_valid,
    output logic [15:0]       instruction,
    output logic [15:0]       immediate,
    output logic [ADDR_W-1:0] inst_pc
);

    fetch_state_t      state;
    logic [15:0]       op_hold;
    logic [ADDR_W-1:0] pc_hold;
    logic              running;
    logic              vec_load;
    logic [ADDR_W-1:0] vec_pc;

    assign running = (state == S_OP) || (state == S_IMM);

`ifdef FETCH_RESET_VECTOR_EN
    localparam fetch_state_t      RESET_STATE = S_VEC_HI;
    localparam logic [ADDR_W-1:0] PC_AT_RESET = '0;
    logic [15:0] vec_hi;

    // Vector words sit at addresses 0 and 1; the high half is held until the low half arrives.
    assign vec_load = !running;
    assign vec_pc   = (state == S_VEC_HI) ? ADDR_W'(1) : ADDR_W'({vec_hi, imem_data});
`else
    localparam fetch_state_t      RESET_STATE = S_OP;
    localparam logic [ADDR_W-1:0] PC_AT_RESET = RESET_PC;

    assign vec_load = 1'b0;
    assign vec_pc   = '0;
`endif

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (PC_AT_RESET)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect && running),
        .redirect_pc (redirect_pc),
        .load        (vec_load),
        .load_pc     (vec_pc),
        .stall       (stall),
        .pc          (imem_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RESET_STATE;
            inst_valid  <= 1'b0;
            instruction <= NOP_INSTR;
            immediate   <= '0;
            inst_pc     <= '0;
            op_hold     <= '0;
            pc_hold     <= '0;
`ifdef FETCH_RESET_VECTOR_EN
            vec_hi      <= '0;
`endif
        end else begin
            case (state)
`ifdef FETCH_RESET_VECTOR_EN
                S_VEC_HI: begin
                    vec_hi <= imem_data;
                    state  <= S_VEC_LO;
                end
                S_VEC_LO: state <= S_OP;
`endif
                default: begin
                    if (redirect) begin
                        // Drop any half-fetched two-word instruction.
                        state       <= S_OP;
                        op_hold     <= '0;
                        pc_hold     <= '0;
                        inst_valid  <= 1'b0;
                        instruction <= NOP_INSTR;
                        immediate   <= '0;
                    end else if (!stall) begin
                        if (state == S_IMM) begin
                            inst_valid  <= 1'b1;
                            instruction <= op_hold;
                            immediate   <= imem_data;
                            inst_pc     <= pc_hold;
                            state       <= S_OP;
                        end else if (imem_data[IMM_BIT]) begin
                            op_hold     <= imem_data;
                            pc_hold     <= imem_addr;
                            inst_valid  <= 1'b0;
                            instruction <= NOP_INSTR;
                            immediate   <= '0;
                            state       <= S_IMM;
                        end else begin
                            inst_valid  <= 1'b1;
                            instruction <= imem_data;
                            immediate   <= '0;
                            inst_pc     <= imem_addr;
                        end
                    end
                end
            endcase
        end
    end

endmodule
